pdm_ctrl: RTL and testbench

PDM_CTRL -- requirements
Module: pdm_ctrl

---
 rtl/pdm_pkg.sv | 14 +
 rtl/pdm_ctrl_if.sv | 11 +
 rtl/pdm_ctrl_fifo.sv | 55 +++++
 rtl/pdm_ctrl.sv | 131 +++++++++++++
 tb/tb_pdm_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM playback controller: sample width, silence level
// and the controller state encoding.
package pdm_pkg;

  localparam int PDM_W = 12;
  localparam logic [PDM_W-1:0] PDM_MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } pdm_state_e;

endpackage

// File: rtl/pdm_ctrl_if.sv
// PCM sample stream into the PDM controller (valid/ready handshake).
interface pdm_ctrl_if;

  logic [pdm_pkg::PDM_W-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/pdm_ctrl_fifo.sv
// Synchronous sample FIFO with flush; read data is the head word, valid while not empty.
module pdm_ctrl_fifo
  import pdm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [PDM_W-1:0]        wdata_i,
  output logic [PDM_W-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [PDM_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pdm_ctrl.sv
// PDM playback controller: buffers PCM samples and releases one to the modulator
// duty register every (period+1) clocks once primed.
//
//   state    | meaning
//   ST_IDLE  | stopped, duty at midscale, FIFO may be pre-filled
//   ST_PRIME | enabled, waiting for at least two buffered samples
//   ST_PLAY  | divider running, one pop per terminal count
module pdm_ctrl
  import pdm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DIV_W-1:0]       period,
  pdm_ctrl_if.slave              in_if,
  output logic [PDM_W-1:0]       duty_cycle,
  output logic                   sample_strobe,
  output logic                   underrun,
  input  logic                   clr_underrun,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  pdm_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PDM_W-1:0] duty_q, duty_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [PDM_W-1:0] fifo_rdata;
  logic             und_set;

  pdm_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (in_if.in_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready depends only on the registered occupancy, never on this cycle's pop.
  assign in_if.in_ready = !fifo_full;
  assign fifo_push      = in_if.in_valid && !fifo_full && !fifo_flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    strobe_d   = 1'b0;
    und_set    = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        duty_d = PDM_MIDSCALE;
        if (en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!en) begin
          state_d    = ST_IDLE;
          fifo_flush = 1'b1;
          duty_d     = PDM_MIDSCALE;
          cnt_d      = '0;
        end else if (fifo_count >= CW'(2)) begin
          state_d = ST_PLAY;
          cnt_d   = period;
        end
      end
      ST_PLAY: begin
        if (!en) begin
          state_d    = ST_IDLE;
          fifo_flush = 1'b1;
          duty_d     = PDM_MIDSCALE;
          cnt_d      = '0;
        end else if (cnt_q == '0) begin
          cnt_d = period;
          if (fifo_empty) begin
            und_set = 1'b1;
          end else begin
            fifo_pop = 1'b1;
            duty_d   = fifo_rdata;
            strobe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        duty_d  = PDM_MIDSCALE;
      end
    endcase
  end

  // Clear wins over a same-cycle underrun set.
  assign underrun_d = clr_underrun ? 1'b0 : (und_set ? 1'b1 : underrun_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      duty_q     <= PDM_MIDSCALE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign duty_cycle    = duty_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_pdm_ctrl.sv
// Directed scenarios plus randomized traffic, each cycle compared against a
// queue-based behavioural model of the playback controller.
module tb_pdm_ctrl;
  import pdm_pkg::*;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
  localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2;

  logic                   clk = 1'b0;
  logic                   rst, en, clr;
  logic [DIV_W-1:0]       period;
  logic [PDM_W-1:0]       duty_cycle;
  logic                   sample_strobe, underrun;
  logic [$clog2(DEPTH):0] fifo_count;

  pdm_ctrl_if pif ();

  pdm_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .period        (period),
    .in_if         (pif),
    .duty_cycle    (duty_cycle),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .clr_underrun  (clr),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model
  logic [PDM_W-1:0] mq[$];
  int               m_mode = M_IDLE;
  int               m_cnt  = 0;
  logic [PDM_W-1:0] m_duty = 12'h800;
  bit               m_strobe = 0;
  bit               m_und = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit push, setund;
    if (rst) begin
      mq.delete();
      m_mode = M_IDLE; m_cnt = 0; m_duty = 12'h800; m_strobe = 0; m_und = 0;
    end else begin
      push   = pif.in_valid && (mq.size() < DEPTH);
      setund = 0;
      m_strobe = 0;
      if (m_mode != M_IDLE && !en) begin
        mq.delete();
        m_mode = M_IDLE; m_duty = 12'h800; m_cnt = 0; push = 0;
      end else begin
        case (m_mode)
          M_IDLE:  if (en) m_mode = M_PRIME;
          M_PRIME: if (mq.size() >= 2) begin m_mode = M_PLAY; m_cnt = int'(period); end
          default: begin
            if (m_cnt == 0) begin
              m_cnt = int'(period);
              if (mq.size() > 0) begin m_duty = mq.pop_front(); m_strobe = 1; end
              else setund = 1;
            end else m_cnt--;
          end
        endcase
      end
      if (push) mq.push_back(pif.in_data);
      if (clr) m_und = 0; else if (setund) m_und = 1;
    end
    @(posedge clk); #1;
    chk("duty", 32'(duty_cycle), 32'(m_duty));
    chk("strobe", 32'(sample_strobe), 32'(m_strobe));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("in_ready", 32'(pif.in_ready), 32'(mq.size() != DEPTH));
  endtask

  int          nstrobe;
  int          t;
  int          st_t[$];
  logic [11:0] st_v[$];

  initial begin
    rst = 1; en = 0; clr = 0; period = '0;
    pif.in_valid = 0; pif.in_data = '0;
    step(); step();
    rst = 0;
    step();
    chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("reset_duty", 32'(duty_cycle), 32'h800);
    chk("reset_ready", 32'(pif.in_ready), 32'd1);

    // enabled with no data: stays priming at midscale
    en = 1; nstrobe = 0;
    repeat (6) begin step(); nstrobe += int'(sample_strobe); end
    chk("prime_state", 32'(dut.state_q), 32'(ST_PRIME));
    chk("prime_duty", 32'(duty_cycle), 32'h800);
    chk("prime_no_strobe", 32'(nstrobe), 32'd0);
    en = 0; step();

    // period 3, three samples
    period = 3; pif.in_valid = 1;
    pif.in_data = 12'h100; step();
    pif.in_data = 12'h200; step();
    pif.in_data = 12'h300; step();
    pif.in_valid = 0; en = 1;
    t = 0;
    repeat (25) begin
      step(); t++;
      if (sample_strobe) begin st_t.push_back(t); st_v.push_back(duty_cycle); end
    end
    chk("p3_nstrobe", 32'(st_t.size()), 32'd3);
    if (st_t.size() == 3) begin
      chk("p3_gap1", 32'(st_t[1] - st_t[0]), 32'd4);
      chk("p3_gap2", 32'(st_t[2] - st_t[1]), 32'd4);
      chk("p3_val0", 32'(st_v[0]), 32'h100);
      chk("p3_val1", 32'(st_v[1]), 32'h200);
      chk("p3_val2", 32'(st_v[2]), 32'h300);
    end
    en = 0; step();
    clr = 1; step(); clr = 0;

    // fill FIFO while idle
    pif.in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin pif.in_data = 12'(16 * i + 5); step(); end
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    chk("full_ready", 32'(pif.in_ready), 32'd0);
    pif.in_data = 12'hABC; step();
    chk("full_extra", 32'(fifo_count), 32'(DEPTH));

    // period 0 from full, pushing every cycle
    period = 0; en = 1;
    pif.in_data = 12'($urandom); step();
    pif.in_data = 12'($urandom); step();
    nstrobe = 0;
    for (int i = 0; i < DEPTH; i++) begin
      pif.in_data = 12'($urandom);
      step();
      nstrobe += int'(sample_strobe);
    end
    chk("p0_strobes", 32'(nstrobe), 32'(DEPTH));
    chk("p0_count", 32'(fifo_count), 32'(DEPTH - 1));
    pif.in_valid = 0; en = 0; step();

    // starvation with period 1
    period = 1; pif.in_valid = 1;
    pif.in_data = 12'h111; step();
    pif.in_data = 12'h222; step();
    pif.in_valid = 0; en = 1;
    repeat (10) step();
    chk("starve_underrun", 32'(underrun), 32'd1);
    chk("starve_hold", 32'(duty_cycle), 32'h222);
    clr = 1; step(); clr = 0;
    chk("clr_underrun", 32'(underrun), 32'd0);
    en = 0; step();

    // drop enable mid-play with three words queued
    period = 20; pif.in_valid = 1;
    pif.in_data = 12'h0A1; step();
    pif.in_data = 12'h0A2; step();
    pif.in_data = 12'h0A3; step();
    pif.in_valid = 0; en = 1;
    repeat (4) step();
    chk("drop_play", 32'(dut.state_q), 32'(ST_PLAY));
    chk("drop_count_pre", 32'(fifo_count), 32'd3);
    en = 0; pif.in_valid = 1; pif.in_data = 12'hFFF; step();
    pif.in_valid = 0;
    chk("drop_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("drop_count", 32'(fifo_count), 32'd0);
    chk("drop_duty", 32'(duty_cycle), 32'h800);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      en           = ($urandom_range(0, 24) != 0);
      clr          = ($urandom_range(0, 29) == 0);
      period       = DIV_W'($urandom_range(0, 3));
      pif.in_valid = ($urandom_range(0, 2) != 0);
      pif.in_data  = 12'($urandom);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
